// File: rtl/test_unit_chain_seq.sv
// -----------------------------------------------------------------------------
// test_unit_chain_seq
//
// Sequencer for a chain of simulation test units. It waits for an upstream
// pass token, then starts NUM_UNITS units one after another, waiting for each
// unit's done/fail report (with an optional per-unit timeout). Once the chain
// ends it raises a sticky downstream pass token together with an overall
// result and per-unit fail / timeout records.
//
// Parameters
//   NUM_UNITS    number of chained units (>= 1)
//   TIMEOUT      cycles a unit may run before it is timed out; 0 = never
//   STOP_ON_FAIL 1 = end the chain after the first failing / timed-out unit
//
// Ports
//   clock         in   single clock
//   rst           in   synchronous active-high reset
//   from_up_pass  in   upstream pass token (level, looked at only in IDLE)
//   unit_done     in   per-unit completion, only the current unit's bit counts
//   unit_fail     in   per-unit fail qualifier, sampled with unit_done
//   unit_start    out  one-hot start level, high while that unit runs
//   cur_unit      out  index of the active (or last) unit
//   busy          out  chain in progress
//   to_down_pass  out  sticky downstream token, set when the chain finishes
//   all_ok        out  overall result, meaningful when to_down_pass = 1
//   fail_vec      out  sticky per-unit fail record (timeouts included)
//   timeout_vec   out  sticky per-unit timeout record
//
// Handshake: unit_start[i] is a level held for the whole run of unit i. The
// unit answers by raising unit_done[i] (with unit_fail[i] valid in the same
// cycle); the first edge that sees it ends the run and drops unit_start. A
// one-cycle gap with no start asserted follows every run so a unit can drop
// its done before the next unit is started.
// -----------------------------------------------------------------------------
module test_unit_chain_seq #(
  parameter int NUM_UNITS    = 4,
  parameter int TIMEOUT      = 1000,
  parameter int STOP_ON_FAIL = 0,
  localparam int IDXW        = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 from_up_pass,
  input  logic [NUM_UNITS-1:0] unit_done,
  input  logic [NUM_UNITS-1:0] unit_fail,
  output logic [NUM_UNITS-1:0] unit_start,
  output logic [IDXW-1:0]      cur_unit,
  output logic                 busy,
  output logic                 to_down_pass,
  output logic                 all_ok,
  output logic [NUM_UNITS-1:0] fail_vec,
  output logic [NUM_UNITS-1:0] timeout_vec
);

  // Timer just wide enough to hold TIMEOUT; one bit when timeouts are off.
  localparam int TW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST   = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam int LAST_UNIT = NUM_UNITS - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e               state_q;
  logic [TW-1:0]        timer_q;
  logic [TW-1:0]        timer_d;
  logic [IDXW-1:0]      cur_q;
  logic [NUM_UNITS-1:0] start_q;
  logic [NUM_UNITS-1:0] fail_q;
  logic [NUM_UNITS-1:0] tout_q;
  logic                 busy_q;
  logic                 pass_q;
  logic                 ok_q;

  logic                 done_cur;
  logic                 fail_cur;
  logic                 timeout_hit;
  logic                 is_last;
  logic                 stop_now;
  logic [IDXW-1:0]      cur_inc;
  logic [NUM_UNITS-1:0] next_onehot;

  // Only the running unit's report is ever looked at.
  assign done_cur    = unit_done[cur_q];
  assign fail_cur    = unit_fail[cur_q];

  // timer_q counts completed cycles of the current run, so the edge that
  // sees TIMEOUT-1 is exactly TIMEOUT edges after the start edge.
  assign timeout_hit = (TIMEOUT != 0) && (timer_q == TW'(TO_LAST));
  assign is_last     = (cur_q == IDXW'(LAST_UNIT));
  assign stop_now    = (STOP_ON_FAIL != 0) && fail_q[cur_q];
  assign cur_inc     = cur_q + IDXW'(1);
  assign next_onehot = NUM_UNITS'(1) << cur_inc;

  // Saturating increment: a unit left running forever with the timeout
  // disabled must not wrap the counter.
  always_comb begin
    timer_d = timer_q;
    if (timer_q != '1) begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      cur_q   <= '0;
      start_q <= '0;
      fail_q  <= '0;
      tout_q  <= '0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (from_up_pass) begin
            state_q <= S_RUN;
            cur_q   <= '0;
            start_q <= NUM_UNITS'(1);
            busy_q  <= 1'b1;
            timer_q <= '0;
          end
        end

        S_RUN: begin
          if (done_cur) begin
            // A done arriving on the timeout edge still wins: the unit's own
            // verdict is recorded and no timeout is flagged.
            fail_q[cur_q] <= fail_cur;
            start_q       <= '0;
            state_q       <= S_GAP;
          end else if (timeout_hit) begin
            tout_q[cur_q] <= 1'b1;
            fail_q[cur_q] <= 1'b1;
            start_q       <= '0;
            state_q       <= S_GAP;
          end else begin
            timer_q <= timer_d;
          end
        end

        S_GAP: begin
          if (is_last || stop_now) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            pass_q  <= 1'b1;
            ok_q    <= ~|fail_q;
          end else begin
            cur_q   <= cur_inc;
            start_q <= next_onehot;
            timer_q <= '0;
            state_q <= S_RUN;
          end
        end

        S_DONE: begin
          // Terminal until reset; the upstream token is no longer looked at.
          state_q <= S_DONE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign unit_start   = start_q;
  assign cur_unit     = cur_q;
  assign busy         = busy_q;
  assign to_down_pass = pass_q;
  assign all_ok       = ok_q;
  assign fail_vec     = fail_q;
  assign timeout_vec  = tout_q;

endmodule

// File: tb/tb_test_unit_chain_seq.sv
// -----------------------------------------------------------------------------
// Bench for test_unit_chain_seq. Three instances share clock and reset:
//   dut_a  NUM_UNITS=4 TIMEOUT=8 STOP_ON_FAIL=0
//   dut_b  NUM_UNITS=4 TIMEOUT=8 STOP_ON_FAIL=1
//   dut_c  NUM_UNITS=1 TIMEOUT=0 STOP_ON_FAIL=0
// dut_a and dut_b see identically behaving units. The reference model turns a
// per-unit behaviour table (done delay / never answers / fail verdict) into a
// schedule of start and end cycles, from which every output is predicted
// cycle by cycle. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_test_unit_chain_seq;

  localparam int TO_A = 8;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  logic       up_a, up_b, up_c;
  logic [3:0] done_a, fail_a, done_b, fail_b;
  logic [0:0] done_c, fail_c;
  logic [3:0] us_a, fv_a, tv_a, us_b, fv_b, tv_b;
  logic [1:0] cu_a, cu_b;
  logic [0:0] us_c, fv_c, tv_c, cu_c;
  logic       busy_a, tdp_a, ok_a, busy_b, tdp_b, ok_b, busy_c, tdp_c, ok_c;

  test_unit_chain_seq #(.NUM_UNITS(4), .TIMEOUT(TO_A), .STOP_ON_FAIL(0)) dut_a (
    .clock(clock), .rst(rst), .from_up_pass(up_a),
    .unit_done(done_a), .unit_fail(fail_a), .unit_start(us_a), .cur_unit(cu_a),
    .busy(busy_a), .to_down_pass(tdp_a), .all_ok(ok_a),
    .fail_vec(fv_a), .timeout_vec(tv_a));

  test_unit_chain_seq #(.NUM_UNITS(4), .TIMEOUT(TO_A), .STOP_ON_FAIL(1)) dut_b (
    .clock(clock), .rst(rst), .from_up_pass(up_b),
    .unit_done(done_b), .unit_fail(fail_b), .unit_start(us_b), .cur_unit(cu_b),
    .busy(busy_b), .to_down_pass(tdp_b), .all_ok(ok_b),
    .fail_vec(fv_b), .timeout_vec(tv_b));

  test_unit_chain_seq #(.NUM_UNITS(1), .TIMEOUT(0), .STOP_ON_FAIL(0)) dut_c (
    .clock(clock), .rst(rst), .from_up_pass(up_c),
    .unit_done(done_c), .unit_fail(fail_c), .unit_start(us_c), .cur_unit(cu_c),
    .busy(busy_c), .to_down_pass(tdp_c), .all_ok(ok_c),
    .fail_vec(fv_c), .timeout_vec(tv_c));

  int n_checks = 0;
  int n_fail   = 0;

  // Unit behaviour table shared by dut_a and dut_b.
  int d_cfg[4];
  bit nv_cfg[4];
  bit fl_cfg[4];

  // Reference schedule, index 0 = dut_a, 1 = dut_b.
  int m_st[2][4];
  int m_en[2][4];
  bit m_ran[2][4];
  bit m_fo[2][4];
  bit m_to[2][4];
  int m_done[2];
  int cnt[2][4];

  task automatic chk(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  // Unit i starts at cycle st, ends at the earlier of its done delay and the
  // timeout (done wins a tie), the next unit starts one cycle later.
  task automatic build_model(input int k, input bit stop);
    int  t;
    bit  abort;
    t     = 0;
    abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_ran[k][i] = 1'b0; m_fo[k][i] = 1'b0; m_to[k][i] = 1'b0;
      m_st[k][i]  = 0;    m_en[k][i] = 0;
      if (!abort) begin
        m_ran[k][i] = 1'b1;
        m_st[k][i]  = t;
        if (nv_cfg[i] || d_cfg[i] > TO_A) begin
          m_en[k][i] = t + TO_A;
          m_fo[k][i] = 1'b1;
          m_to[k][i] = 1'b1;
        end else begin
          m_en[k][i] = t + d_cfg[i];
          m_fo[k][i] = fl_cfg[i];
        end
        t = m_en[k][i] + 1;
        if (stop && m_fo[k][i]) abort = 1'b1;
      end
    end
    m_done[k] = t;
  endtask

  task automatic check_cycle(input int k, input int t, input logic [3:0] us, input logic [1:0] cu,
                             input logic busy, input logic tdp, input logic ok,
                             input logic [3:0] fv, input logic [3:0] tv);
    logic [3:0] e_us, e_fv, e_tv, fin_fv;
    logic [1:0] e_cu;
    string      p;
    p = (k == 0) ? "a" : "b";
    e_us = '0; e_fv = '0; e_tv = '0; fin_fv = '0; e_cu = '0;
    for (int i = 0; i < 4; i++) begin
      if (m_ran[k][i]) begin
        if (m_st[k][i] <= t) e_cu = 2'(i);
        if (m_st[k][i] <= t && t < m_en[k][i]) e_us[i] = 1'b1;
        if (m_en[k][i] <= t) begin
          e_fv[i] = m_fo[k][i];
          e_tv[i] = m_to[k][i];
        end
        fin_fv[i] = m_fo[k][i];
      end
    end
    chk({p, "_unit_start"},   t, 32'(us),   32'(e_us));
    chk({p, "_cur_unit"},     t, 32'(cu),   32'(e_cu));
    chk({p, "_busy"},         t, 32'(busy), 32'(t < m_done[k]));
    chk({p, "_to_down_pass"}, t, 32'(tdp),  32'(t >= m_done[k]));
    chk({p, "_all_ok"},       t, 32'(ok),   32'((t >= m_done[k]) && (fin_fv == 4'b0)));
    chk({p, "_fail_vec"},     t, 32'(fv),   32'(e_fv));
    chk({p, "_timeout_vec"},  t, 32'(tv),   32'(e_tv));
  endtask

  // Unit behaviour: answer d cycles after start (never if nv_cfg). Fail bits
  // carry noise when done is low, and already-finished units occasionally
  // pulse a stray done that must be ignored.
  task automatic next_drive(input int k, input logic [3:0] us, output logic [3:0] dn, output logic [3:0] fl);
    for (int i = 0; i < 4; i++) begin
      if (us[i]) cnt[k][i]++;
      dn[i] = us[i] && !nv_cfg[i] && (cnt[k][i] == d_cfg[i]);
      fl[i] = dn[i] ? fl_cfg[i] : 1'($urandom_range(0, 1));
      if (!us[i] && cnt[k][i] > 0 && $urandom_range(0, 7) == 0) dn[i] = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst = 1'b1;
    up_a = 1'b0; up_b = 1'b0; up_c = 1'b0;
    done_a = '0; fail_a = '0; done_b = '0; fail_b = '0; done_c = '0; fail_c = '0;
    repeat (2) @(negedge clock);
    chk("rst_a_outputs", 0, 32'({us_a, cu_a, busy_a, tdp_a, ok_a, fv_a, tv_a}), 32'd0);
    chk("rst_b_outputs", 0, 32'({us_b, cu_b, busy_b, tdp_b, ok_b, fv_b, tv_b}), 32'd0);
    chk("rst_c_outputs", 0, 32'({us_c, cu_c, busy_c, tdp_c, ok_c, fv_c, tv_c}), 32'd0);
    rst = 1'b0;
  endtask

  task automatic set_cfg(input int d);
    for (int i = 0; i < 4; i++) begin
      d_cfg[i] = d; nv_cfg[i] = 1'b0; fl_cfg[i] = 1'b0;
    end
  endtask

  task automatic run_both();
    int tmax;
    build_model(0, 1'b0);
    build_model(1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cnt[0][i] = 0; cnt[1][i] = 0;
    end
    do_reset();
    up_a = 1'b1; up_b = 1'b1;
    tmax = ((m_done[0] > m_done[1]) ? m_done[0] : m_done[1]) + 3;
    for (int t = 0; t < tmax; t++) begin
      @(negedge clock);
      // Token drops right after the start, comes back once the chain is done.
      up_a = (t >= m_done[0]);
      up_b = (t >= m_done[1]);
      check_cycle(0, t, us_a, cu_a, busy_a, tdp_a, ok_a, fv_a, tv_a);
      check_cycle(1, t, us_b, cu_b, busy_b, tdp_b, ok_b, fv_b, tv_b);
      next_drive(0, us_a, done_a, fail_a);
      next_drive(1, us_b, done_b, fail_b);
    end
    done_a = '0; done_b = '0;
  endtask

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    up_a = 1'b0; up_b = 1'b0; up_c = 1'b0;
    done_a = '0; fail_a = '0; done_b = '0; fail_b = '0; done_c = '0; fail_c = '0;

    // Token held during reset is ignored; spurious done; reset mid-run.
    @(negedge clock);
    rst = 1'b1; up_a = 1'b1;
    repeat (2) @(negedge clock);
    chk("pass_in_reset_busy", 0, 32'(busy_a), 32'd0);
    chk("pass_in_reset_start", 0, 32'(us_a), 32'd0);
    rst = 1'b0;
    @(negedge clock);
    chk("first_start", 0, 32'(us_a), 32'h1);
    chk("first_busy", 0, 32'(busy_a), 32'd1);
    up_a = 1'b0;
    done_a = 4'b1000; fail_a = 4'b1000;
    @(negedge clock);
    done_a = '0; fail_a = '0;
    chk("spurious_start", 1, 32'(us_a), 32'h1);
    chk("spurious_cur", 1, 32'(cu_a), 32'd0);
    chk("spurious_fail_vec", 1, 32'(fv_a), 32'd0);
    chk("spurious_timeout_vec", 1, 32'(tv_a), 32'd0);
    @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    chk("midrun_reset_outputs", 0, 32'({us_a, cu_a, busy_a, tdp_a, ok_a, fv_a, tv_a}), 32'd0);
    rst = 1'b0;
    @(negedge clock);
    chk("idle_after_reset_busy", 1, 32'(busy_a), 32'd0);
    up_a = 1'b1;
    @(negedge clock);
    chk("restart_start", 0, 32'(us_a), 32'h1);
    chk("restart_cur", 0, 32'(cu_a), 32'd0);
    up_a = 1'b0;

    // Directed chains.
    set_cfg(5);                                   run_both();  // nominal
    set_cfg(5); fl_cfg[2] = 1'b1;                 run_both();  // unit 2 fails
    set_cfg(5); fl_cfg[1] = 1'b1;                 run_both();  // unit 1 fails
    set_cfg(5); nv_cfg[0] = 1'b1;                 run_both();  // unit 0 times out
    set_cfg(5); d_cfg[0] = TO_A;                  run_both();  // done on timeout edge
    set_cfg(5); d_cfg[0] = TO_A; fl_cfg[0] = 1'b1; run_both(); // tie, unit reports fail
    set_cfg(5); d_cfg[3] = TO_A + 1;              run_both();  // one cycle too late
    set_cfg(1);                                   run_both();  // fastest units
    set_cfg(1); for (int i = 0; i < 4; i++) nv_cfg[i] = 1'b1; run_both();

    // Randomised chains.
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 4; i++) begin
        d_cfg[i]  = int'($urandom_range(1, TO_A + 2));
        nv_cfg[i] = ($urandom_range(0, 5) == 0);
        fl_cfg[i] = ($urandom_range(0, 3) == 0);
      end
      run_both();
    end

    // Single unit, timeout disabled: runs indefinitely until done.
    do_reset();
    up_c = 1'b1;
    @(negedge clock);
    chk("c_start", 0, 32'(us_c), 32'h1);
    chk("c_busy", 0, 32'(busy_c), 32'd1);
    up_c = 1'b0;
    repeat (300) @(negedge clock);
    chk("c_long_start", 300, 32'(us_c), 32'h1);
    chk("c_long_busy", 300, 32'(busy_c), 32'd1);
    chk("c_long_timeout_vec", 300, 32'(tv_c), 32'd0);
    chk("c_long_fail_vec", 300, 32'(fv_c), 32'd0);
    done_c = 1'b1; fail_c = 1'b0;
    @(negedge clock);
    done_c = 1'b0;
    chk("c_gap_start", 301, 32'(us_c), 32'd0);
    chk("c_gap_busy", 301, 32'(busy_c), 32'd1);
    chk("c_gap_pass", 301, 32'(tdp_c), 32'd0);
    @(negedge clock);
    chk("c_done_pass", 302, 32'(tdp_c), 32'd1);
    chk("c_done_ok", 302, 32'(ok_c), 32'd1);
    chk("c_done_busy", 302, 32'(busy_c), 32'd0);
    chk("c_done_cur", 302, 32'(cu_c), 32'd0);
    up_c = 1'b1;
    repeat (3) @(negedge clock);
    chk("c_no_rerun_start", 305, 32'(us_c), 32'd0);
    chk("c_no_rerun_pass", 305, 32'(tdp_c), 32'd1);
    chk("c_no_rerun_busy", 305, 32'(busy_c), 32'd0);
    up_c = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
